// File: rtl/rb_sysbus_master_if.sv
// Command, response and register-bus signals of the RadioBox system-bus initiator.
// master: initiator view; slave: command source, response sink and bus target.
interface rb_sysbus_master_if;
    logic        cmd_vld;
    logic        cmd_rdy;
    logic        cmd_we;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_sel;

    logic        rsp_vld;
    logic        rsp_rdy;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_tout;

    logic [31:0] sys_addr;
    logic [31:0] sys_wdata;
    logic [3:0]  sys_sel;
    logic        sys_wen;
    logic        sys_ren;
    logic [31:0] sys_rdata;
    logic        sys_err;
    logic        sys_ack;

    modport master (
        input  cmd_vld, cmd_we, cmd_addr, cmd_wdata, cmd_sel, rsp_rdy,
               sys_rdata, sys_err, sys_ack,
        output cmd_rdy, rsp_vld, rsp_rdata, rsp_err, rsp_tout,
               sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren
    );

    modport slave (
        output cmd_vld, cmd_we, cmd_addr, cmd_wdata, cmd_sel, rsp_rdy,
               sys_rdata, sys_err, sys_ack,
        input  cmd_rdy, rsp_vld, rsp_rdata, rsp_err, rsp_tout,
               sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren
    );
endinterface

// File: rtl/rb_sysbus_master.sv
// RadioBox system-bus initiator: command FIFO feeding a strobe/ack bus engine.
// Optional WAIT timeout enabled by defining RB_SYSBUS_MASTER_TIMEOUT_EN.
module rb_sysbus_master #(
    parameter int unsigned FIFO_AW  = 3,
    parameter int unsigned TOUT_CYC = 255
) (
    input  logic                 clk_adc_125mhz,
    input  logic                 adc_rstn_i,
    rb_sysbus_master_if.master   bus,
    output logic                 busy,
    output logic [FIFO_AW:0]     fifo_level
);
    localparam int unsigned LW    = FIFO_AW + 1;
    localparam int unsigned DEPTH = 1 << FIFO_AW;

    if (TOUT_CYC < 2) begin : g_tout_chk
        $error("TOUT_CYC must be at least 2");
    end

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t             state;
    cmd_t               mem [DEPTH];
    cmd_t               head;
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [LW-1:0]      level;
    logic [LW-1:0]      level_nxt;
    logic               push;
    logic               pop;
    logic               cmd_rdy;
    logic               cur_we;
    logic [31:0]        sys_addr;
    logic [31:0]        sys_wdata;
    logic [3:0]         sys_sel;
    logic               sys_wen;
    logic               sys_ren;
    logic               rsp_vld;
    logic [31:0]        rsp_rdata;
    logic               rsp_err;

`ifdef RB_SYSBUS_MASTER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TOUT_CYC);
    logic [TW-1:0]      tcnt;
    logic               rsp_tout;
    assign bus.rsp_tout = rsp_tout;
`else
    assign bus.rsp_tout = 1'b0;
`endif

    assign bus.cmd_rdy   = cmd_rdy;
    assign bus.rsp_vld   = rsp_vld;
    assign bus.rsp_rdata = rsp_rdata;
    assign bus.rsp_err   = rsp_err;
    assign bus.sys_addr  = sys_addr;
    assign bus.sys_wdata = sys_wdata;
    assign bus.sys_sel   = sys_sel;
    assign bus.sys_wen   = sys_wen;
    assign bus.sys_ren   = sys_ren;
    assign fifo_level    = level;

    // cmd_rdy is registered "not full", so a full FIFO refuses a push even when popping.
    always_comb begin
        push      = bus.cmd_vld && cmd_rdy;
        pop       = (state == ST_IDLE) && (level != '0);
        level_nxt = level + LW'(push) - LW'(pop);
        head      = mem[rd_ptr];
    end

    // Command FIFO storage, pointers and occupancy.
    always_ff @(posedge clk_adc_125mhz or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            cmd_rdy <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= cmd_t'{bus.cmd_we, bus.cmd_addr, bus.cmd_wdata, bus.cmd_sel};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            level   <= level_nxt;
            cmd_rdy <= (level_nxt != LW'(DEPTH));
        end
    end

    // Transaction engine: one outstanding command, ack ignored outside WAIT.
    always_ff @(posedge clk_adc_125mhz or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            state     <= ST_IDLE;
            cur_we    <= 1'b0;
            sys_addr  <= '0;
            sys_wdata <= '0;
            sys_sel   <= '0;
            sys_wen   <= 1'b0;
            sys_ren   <= 1'b0;
            rsp_vld   <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
`ifdef RB_SYSBUS_MASTER_TIMEOUT_EN
            tcnt      <= '0;
            rsp_tout  <= 1'b0;
`endif
        end else begin
            busy <= (level_nxt != '0) || (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        sys_addr  <= head.addr;
                        sys_wdata <= head.wdata;
                        sys_sel   <= head.sel;
                        cur_we    <= head.we;
                        sys_wen   <= head.we;
                        sys_ren   <= !head.we;
                        busy      <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    sys_wen <= 1'b0;
                    sys_ren <= 1'b0;
`ifdef RB_SYSBUS_MASTER_TIMEOUT_EN
                    tcnt    <= '0;
`endif
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.sys_ack) begin
                        rsp_rdata <= cur_we ? 32'h0 : bus.sys_rdata;
                        rsp_err   <= bus.sys_err;
                        rsp_vld   <= 1'b1;
`ifdef RB_SYSBUS_MASTER_TIMEOUT_EN
                        rsp_tout  <= 1'b0;
`endif
                        state     <= ST_RESP;
                    end
`ifdef RB_SYSBUS_MASTER_TIMEOUT_EN
                    else if (tcnt == TW'(TOUT_CYC - 1)) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        rsp_tout  <= 1'b1;
                        rsp_vld   <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
`endif
                end
                ST_RESP: begin
                    if (bus.rsp_rdy) begin
                        rsp_vld <= 1'b0;
                        busy    <= (level_nxt != '0);
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
